// File: rtl/coco_bus_pkg.sv
// Shared definitions for the coco data-memory bus demultiplexer:
// state encoding, slave indices and the default address map.
package coco_bus_pkg;

  // State encoding of the dispatch FSM.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    RESP  = ST_RESP
  } state_t;

  // Slave port indices; lower index wins when regions overlap.
  localparam int SL_RAM  = 0;
  localparam int SL_TMR  = 1;
  localparam int SL_UART = 2;
  localparam int SL_GPIO = 3;

  // Default address map: 16 KiB RAM at 0, 16-byte peripheral windows above.
  localparam logic [31:0] DEF_BASE0 = 32'h0000_0000;
  localparam logic [31:0] DEF_BASE1 = 32'h0000_7F00;
  localparam logic [31:0] DEF_BASE2 = 32'h0000_7F10;
  localparam logic [31:0] DEF_BASE3 = 32'h0000_7F20;

  localparam logic [31:0] DEF_MASK0 = 32'hFFFF_C000;
  localparam logic [31:0] DEF_MASK1 = 32'hFFFF_FFF0;
  localparam logic [31:0] DEF_MASK2 = 32'hFFFF_FFF0;
  localparam logic [31:0] DEF_MASK3 = 32'hFFFF_FFF0;

endpackage

// File: rtl/coco_bus_decode.sv
// Combinational address decoder: compares the address against four
// base/mask regions and priority-encodes the hits to a one-hot select.
module coco_bus_decode
  import coco_bus_pkg::*;
#(
  parameter int            AW    = 32,
  parameter logic [AW-1:0] BASE0 = AW'(DEF_BASE0),
  parameter logic [AW-1:0] BASE1 = AW'(DEF_BASE1),
  parameter logic [AW-1:0] BASE2 = AW'(DEF_BASE2),
  parameter logic [AW-1:0] BASE3 = AW'(DEF_BASE3),
  parameter logic [AW-1:0] MASK0 = AW'(DEF_MASK0),
  parameter logic [AW-1:0] MASK1 = AW'(DEF_MASK1),
  parameter logic [AW-1:0] MASK2 = AW'(DEF_MASK2),
  parameter logic [AW-1:0] MASK3 = AW'(DEF_MASK3)
) (
  input  logic [AW-1:0] addr,
  output logic          hit_any,
  output logic [3:0]    sel
);

  logic [3:0] hit;

  // Raw region match for every slave.
  always_comb begin
    hit[SL_RAM]  = ((addr & MASK0) == (BASE0 & MASK0));
    hit[SL_TMR]  = ((addr & MASK1) == (BASE1 & MASK1));
    hit[SL_UART] = ((addr & MASK2) == (BASE2 & MASK2));
    hit[SL_GPIO] = ((addr & MASK3) == (BASE3 & MASK3));
  end

  // Priority encode: lowest matching index becomes the one-hot select.
  always_comb begin
    // NOTE: default first so every path assigns sel and no latch is inferred.
    sel = '0;
    if (hit[SL_RAM])       sel[SL_RAM]  = 1'b1;
    else if (hit[SL_TMR])  sel[SL_TMR]  = 1'b1;
    else if (hit[SL_UART]) sel[SL_UART] = 1'b1;
    else if (hit[SL_GPIO]) sel[SL_GPIO] = 1'b1;
  end

  assign hit_any = |hit;

endmodule

// File: rtl/coco_bus_demux.sv
// 1-to-4 data-memory request dispatcher. Registers a master request,
// drives one slave with a one-hot strobe, waits for its ack (or a
// timeout) and returns a single-cycle completion to the master.
module coco_bus_demux
  import coco_bus_pkg::*;
#(
  parameter int            AW     = 32,
  parameter int            DW     = 32,
  parameter logic [AW-1:0] BASE0  = AW'(DEF_BASE0),
  parameter logic [AW-1:0] BASE1  = AW'(DEF_BASE1),
  parameter logic [AW-1:0] BASE2  = AW'(DEF_BASE2),
  parameter logic [AW-1:0] BASE3  = AW'(DEF_BASE3),
  parameter logic [AW-1:0] MASK0  = AW'(DEF_MASK0),
  parameter logic [AW-1:0] MASK1  = AW'(DEF_MASK1),
  parameter logic [AW-1:0] MASK2  = AW'(DEF_MASK2),
  parameter logic [AW-1:0] MASK3  = AW'(DEF_MASK3),
  parameter int            TO_CYC = 255
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            M_Req,
  input  logic            M_We,
  input  logic [AW-1:0]   M_Addr,
  input  logic [DW-1:0]   M_WData,
  input  logic [DW/8-1:0] M_BE,
  output logic            M_Ack,
  output logic            M_Err,
  output logic [DW-1:0]   M_RData,
  output logic [3:0]      S_Req,
  output logic            S_We,
  output logic [AW-1:0]   S_Addr,
  output logic [DW-1:0]   S_WData,
  output logic [DW/8-1:0] S_BE,
  input  logic [3:0]      S_Ack,
  input  logic [DW-1:0]   S_RData0,
  input  logic [DW-1:0]   S_RData1,
  input  logic [DW-1:0]   S_RData2,
  input  logic [DW-1:0]   S_RData3
);

  // Last counter value still allowed in ISSUE; the counter starts at 0.
  localparam logic [15:0] TO_LAST = 16'(TO_CYC - 1);

  state_t        state;
  logic [15:0]   cnt;
  logic          dec_hit_any;
  logic [3:0]    dec_sel;
  logic          ack_sel;
  logic [DW-1:0] rdata_sel;

  coco_bus_decode #(
    .AW   (AW),
    .BASE0(BASE0), .BASE1(BASE1), .BASE2(BASE2), .BASE3(BASE3),
    .MASK0(MASK0), .MASK1(MASK1), .MASK2(MASK2), .MASK3(MASK3)
  ) u_decode (
    .addr   (M_Addr),
    .hit_any(dec_hit_any),
    .sel    (dec_sel)
  );

  // Only the ack of the currently strobed slave completes the transfer.
  assign ack_sel = |(S_Ack & S_Req);

  // Read-data return mux steered by the held one-hot request.
  always_comb begin
    rdata_sel = '0;
    if (S_Req[SL_RAM])       rdata_sel = S_RData0;
    else if (S_Req[SL_TMR])  rdata_sel = S_RData1;
    else if (S_Req[SL_UART]) rdata_sel = S_RData2;
    else if (S_Req[SL_GPIO]) rdata_sel = S_RData3;
  end

  // Dispatch FSM with all outputs registered.
  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!Rst_n) begin
      // NOTE: every register is cleared; reset can land mid-transfer and
      // must leave no stale strobe or completion behind.
      state   <= IDLE;
      cnt     <= '0;
      M_Ack   <= 1'b0;
      M_Err   <= 1'b0;
      M_RData <= '0;
      S_Req   <= '0;
      S_We    <= 1'b0;
      S_Addr  <= '0;
      S_WData <= '0;
      S_BE    <= '0;
    end else begin
      M_Ack <= 1'b0;
      case (state)
        IDLE: begin
          if (M_Req) begin
            S_We    <= M_We;
            S_Addr  <= M_Addr;
            S_WData <= M_WData;
            S_BE    <= M_BE;
            M_RData <= '0;
            if (dec_hit_any) begin
              S_Req <= dec_sel;
              cnt   <= '0;
              M_Err <= 1'b0;
              state <= ISSUE;
            end else begin
              S_Req <= '0;
              M_Err <= 1'b1;
              M_Ack <= 1'b1;
              state <= RESP;
            end
          end
        end
        ISSUE: begin
          if (ack_sel) begin
            // Ack beats a timeout expiring in the same cycle.
            M_RData <= S_We ? '0 : rdata_sel;
            M_Err   <= 1'b0;
            S_Req   <= '0;
            M_Ack   <= 1'b1;
            state   <= RESP;
          end else if (cnt == TO_LAST) begin
            M_RData <= '0;
            M_Err   <= 1'b1;
            S_Req   <= '0;
            M_Ack   <= 1'b1;
            state   <= RESP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coco_bus_demux.sv
// Self-checking bench for coco_bus_demux: directed scenarios plus random
// transactions scored against an address-range / latency reference model.
module tb_coco_bus_demux;

  localparam int TO_CYC = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic        m_ack, m_err;
  logic [31:0] m_rdata;
  logic [3:0]  s_req;
  logic        s_we;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;
  logic [3:0]  s_ack;
  logic [31:0] s_rdata0, s_rdata1, s_rdata2, s_rdata3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  coco_bus_demux #(.TO_CYC(TO_CYC)) dut (
    .Clk     (clk),
    .Rst_n   (rst_n),
    .M_Req   (m_req),
    .M_We    (m_we),
    .M_Addr  (m_addr),
    .M_WData (m_wdata),
    .M_BE    (m_be),
    .M_Ack   (m_ack),
    .M_Err   (m_err),
    .M_RData (m_rdata),
    .S_Req   (s_req),
    .S_We    (s_we),
    .S_Addr  (s_addr),
    .S_WData (s_wdata),
    .S_BE    (s_be),
    .S_Ack   (s_ack),
    .S_RData0(s_rdata0),
    .S_RData1(s_rdata1),
    .S_RData2(s_rdata2),
    .S_RData3(s_rdata3)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference address map as plain ranges; -1 means unmapped.
  function automatic int ref_slave(input logic [31:0] addr);
    if (addr < 32'h0000_4000)                              return 0;
    if (addr >= 32'h0000_7F00 && addr < 32'h0000_7F10)     return 1;
    if (addr >= 32'h0000_7F10 && addr < 32'h0000_7F20)     return 2;
    if (addr >= 32'h0000_7F20 && addr < 32'h0000_7F30)     return 3;
    return -1;
  endfunction

  // One master transaction. Entry and exit: at a negedge with the DUT idle.
  // ack_dly = ISSUE cycle (1-based) in which the slave acks; outside
  // 1..TO_CYC means the slave never acks. hold keeps M_Req high throughout.
  task automatic run_txn(input logic [31:0] addr, input logic we,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input int ack_dly, input bit hold, input bit stray);
    int          sl, exp_lat, cyc;
    logic [3:0]  oh, stray_oh;
    logic [31:0] rd[4];
    logic [31:0] exp_rdata;
    logic        exp_err;
    bit          done;

    sl = ref_slave(addr);
    for (int i = 0; i < 4; i++) rd[i] = $urandom;
    s_rdata0 = rd[0]; s_rdata1 = rd[1]; s_rdata2 = rd[2]; s_rdata3 = rd[3];
    oh       = (sl >= 0) ? 4'(1 << sl) : 4'b0000;
    stray_oh = (oh == 4'b0001) ? 4'b0010 : 4'b0001;

    if (sl < 0) begin
      exp_lat = 1; exp_err = 1'b1; exp_rdata = '0;
    end else if (ack_dly >= 1 && ack_dly <= TO_CYC) begin
      exp_lat = ack_dly + 1; exp_err = 1'b0; exp_rdata = we ? 32'h0 : rd[sl];
    end else begin
      exp_lat = TO_CYC + 1; exp_err = 1'b1; exp_rdata = '0;
    end

    m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wdata; m_be = be;
    s_ack = 4'b0000;
    cyc = 0; done = 0;
    while (!done && cyc < 100) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      // Scramble master inputs: the slave side must keep the captured copy.
      if (!hold) m_req = 1'b0;
      m_addr = $urandom; m_wdata = $urandom; m_we = ~we; m_be = ~be;
      if (m_ack) begin
        done = 1;
      end else begin
        check("s_req_issue", {28'h0, s_req}, {28'h0, oh});
        check("s_wdata_stable", s_wdata, wdata);
        check("s_addr_stable", s_addr, addr);
        if (cyc == ack_dly)              s_ack = oh;
        else if (stray && cyc == 2)      s_ack = stray_oh;
        else                             s_ack = 4'b0000;
      end
    end
    check("m_ack_seen", {31'h0, done}, 32'h1);
    check("latency", 32'(cyc), 32'(exp_lat));
    check("m_err", {31'h0, m_err}, {31'h0, exp_err});
    check("m_rdata", m_rdata, exp_rdata);
    check("s_req_resp", {28'h0, s_req}, 32'h0);
    check("s_we", {31'h0, s_we}, {31'h0, we});
    check("s_be", {28'h0, s_be}, {28'h0, be});
    s_ack = 4'b0000;
    @(posedge clk); @(negedge clk);
    check("m_ack_pulse", {31'h0, m_ack}, 32'h0);
    check("s_req_idle", {28'h0, s_req}, 32'h0);
  endtask

  initial begin
    int kind, dly;
    logic [31:0] a;

    rst_n = 1'b0; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_be = '0;
    s_ack = '0; s_rdata0 = '0; s_rdata1 = '0; s_rdata2 = '0; s_rdata3 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_ack", {31'h0, m_ack}, 32'h0);
    check("rst_m_err", {31'h0, m_err}, 32'h0);
    check("rst_m_rdata", m_rdata, 32'h0);
    check("rst_s_req", {28'h0, s_req}, 32'h0);
    check("rst_s_addr", s_addr, 32'h0);
    check("rst_s_wdata", s_wdata, 32'h0);
    check("rst_s_be_we", {27'h0, s_be, s_we}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed scenarios.
    run_txn(32'h0000_0100, 1'b0, 32'h0, 4'hF, 1, 0, 0);   // RAM read, first-cycle ack
    run_txn(32'h0000_7F14, 1'b1, 32'h41, 4'hF, 3, 0, 0);  // UART write, ack after 3
    run_txn(32'h0001_0000, 1'b0, 32'h0, 4'hF, 1, 0, 0);   // unmapped
    run_txn(32'h0000_7F20, 1'b0, 32'h0, 4'hF, 0, 0, 1);   // GPIO timeout with stray ack
    run_txn(32'h0000_7F28, 1'b0, 32'h0, 4'h3, TO_CYC, 0, 0);     // ack on expiry cycle wins
    run_txn(32'h0000_7F2C, 1'b1, 32'h5, 4'h1, TO_CYC + 1, 0, 0); // one cycle too late
    run_txn(32'h0000_3FFC, 1'b0, 32'h0, 4'hF, 1, 0, 0);   // top of RAM
    run_txn(32'h0000_4000, 1'b0, 32'h0, 4'hF, 1, 0, 0);   // just past RAM
    run_txn(32'h0000_7F30, 1'b0, 32'h0, 4'hF, 1, 0, 0);   // just past GPIO

    // Back-to-back RAM reads with M_Req held high.
    run_txn(32'h0000_0200, 1'b0, 32'h0, 4'hF, 1, 1, 0);
    run_txn(32'h0000_0204, 1'b0, 32'h0, 4'hF, 2, 1, 0);
    m_req = 1'b0;
    @(negedge clk);

    // Reset while the timer is being strobed.
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_7F04; m_wdata = 32'h0; m_be = 4'hF;
    @(posedge clk); @(negedge clk);
    m_req = 1'b0;
    check("rst_mid_pre", {28'h0, s_req}, 32'h2);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_s_req", {28'h0, s_req}, 32'h0);
    check("rst_mid_m_ack", {31'h0, m_ack}, 32'h0);
    check("rst_mid_s_addr", s_addr, 32'h0);
    s_ack = 4'b0010;  // late ack from the aborted slave must not complete anything
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      check("rst_mid_no_ack", {31'h0, m_ack}, 32'h0);
    end
    s_ack = 4'b0000;
    run_txn(32'h0000_7F08, 1'b0, 32'h0, 4'hF, 1, 0, 0);

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0:       a = {18'h0, 14'($urandom)};
        1:       a = 32'h0000_7F00 | 32'($urandom_range(0, 15));
        2:       a = 32'h0000_7F10 | 32'($urandom_range(0, 15));
        3:       a = 32'h0000_7F20 | 32'($urandom_range(0, 15));
        4:       a = 32'h0000_7F30 + 32'($urandom_range(0, 255));
        default: a = $urandom;
      endcase
      dly = $urandom_range(0, TO_CYC + 2);
      run_txn(a, 1'($urandom), $urandom, 4'($urandom), dly,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      m_req = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
